// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues one SRAM read per cycle,
// and captures branch redirects that arrive while the PC cannot advance.
module if_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  stall,
    input  logic        br_e,
    input  logic [63:0] br_addr,
    input  logic        inst_sram_ready,
    output logic        inst_sram_en,
    output logic [63:0] inst_sram_addr,
    output logic        pc_valid,
    output logic [63:0] pc,
    output logic        stallreq_if
);

    typedef enum logic [1:0] {
        StBoot  = 2'd0,
        StFetch = 2'd1,
        StWait  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] fetch_pc_q, fetch_pc_d;
    logic        pend_v_q, pend_v_d;
    logic [63:0] pend_addr_q, pend_addr_d;
    logic        pc_update;

    // Only stall[0] belongs to this stage; the other bits serve later stages.
    logic unused_stall;
    assign unused_stall = ^stall[5:1];

    // State register; reset abandons any WAIT or pending redirect immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StBoot;
            fetch_pc_q  <= RESET_PC;
            pend_v_q    <= 1'b0;
            pend_addr_q <= 64'h0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            pend_v_q    <= pend_v_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    // Next-state: FSM transitions, PC advance/redirect, and redirect capture.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        pend_v_d    = pend_v_q;
        pend_addr_d = pend_addr_q;
        pc_update   = (state_q == StFetch) && !stall[0] && inst_sram_ready;

        unique case (state_q)
            StBoot:  state_d = StFetch;
            StFetch: if (!inst_sram_ready) state_d = StWait;
            StWait:  if (inst_sram_ready) state_d = StFetch;
            default: state_d = StBoot;
        endcase

        if (pc_update) begin
            // Redirect targets are forced to a 4-byte boundary when loaded.
            if (br_e) begin
                fetch_pc_d = {br_addr[63:2], 2'b00};
            end else if (pend_v_q) begin
                fetch_pc_d = {pend_addr_q[63:2], 2'b00};
            end else begin
                fetch_pc_d = fetch_pc_q + 64'd4;
            end
            pend_v_d = 1'b0;
        end else if (br_e) begin
            // PC frozen this cycle: remember the newest redirect for later.
            pend_v_d    = 1'b1;
            pend_addr_d = br_addr;
        end
    end

    // Outputs: SRAM request and handshake status, purely combinational.
    always_comb begin
        inst_sram_en   = (state_q != StBoot);
        inst_sram_addr = {fetch_pc_q[63:3], 3'b000};
        pc             = fetch_pc_q;
        pc_valid       = inst_sram_en & inst_sram_ready;
        stallreq_if    = inst_sram_en & ~inst_sram_ready;
    end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0000_0000_8000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port stall  input  6  pipeline stall vector; bit 0 holds this stage.
REQ-005 SHALL have port br_e  input  1  branch/jump redirect request from execute.
REQ-006 SHALL have port br_addr  input  64  redirect target, valid when br_e=1.
REQ-007 SHALL have port inst_sram_ready  input  1  instruction SRAM accepts a read this cycle.
REQ-008 SHALL have port inst_sram_en  output  1  instruction SRAM read enable.
REQ-009 SHALL have port inst_sram_addr  output  64  read address, doubleword-aligned.
REQ-010 SHALL have port pc_valid  output  1  pc carries a fetch accepted this cycle.
REQ-011 SHALL have port pc  output  64  address of the instruction being fetched.
REQ-012 SHALL have port stallreq_if  output  1  stall request to the pipeline controller.

Function
REQ-013 SHALL hold state in fetch_pc (64b), pend_v (1b), pend_addr (64b) and a state machine with states BOOT, FETCH, WAIT.
REQ-014 SHALL leave BOOT for FETCH on the first clock edge after rst_n deasserts; no fetch is issued in BOOT.
REQ-015 SHALL, in FETCH and WAIT, drive inst_sram_en=1 and inst_sram_addr={fetch_pc[63:3],3'b000}; in BOOT, inst_sram_en=0.
REQ-016 SHALL drive pc=fetch_pc and pc_valid=inst_sram_en & inst_sram_ready, combinationally.
REQ-017 SHALL drive stallreq_if=1 exactly when inst_sram_en=1 and inst_sram_ready=0.
REQ-018 SHALL move FETCH->WAIT when inst_sram_ready=0, and WAIT->FETCH when inst_sram_ready=1.
REQ-019 SHALL not change fetch_pc while in WAIT or while stall[0]=1.
REQ-020 SHALL update fetch_pc, when in FETCH with stall[0]=0 and inst_sram_ready=1, as follows (priority order):
- br_e=1: load br_addr.
- else pend_v=1: load pend_addr.
- else: load fetch_pc+4, modulo 2^64 (wraps 64'hFFFF_FFFF_FFFF_FFFC -> 0).
REQ-021 SHALL, when br_e=1 and fetch_pc is not updated this cycle (stall[0]=1, WAIT or BOOT), set pend_v=1 and pend_addr=br_addr; a later br_e overwrites pend_addr.
REQ-022 SHALL clear pend_v in the cycle a redirect (br_e or pending) is applied to fetch_pc.
REQ-023 SHALL force bits [1:0] of any loaded redirect target to 2'b00.
REQ-024 SHALL issue no transaction other than the current fetch_pc read; the sequential SRAM read data is returned to decode one cycle later and is not consumed here.

Reset
REQ-025 SHALL, while rst_n=0, hold state=BOOT, fetch_pc=RESET_PC, pend_v=0 and pend_addr=0, which forces inst_sram_en=0, pc_valid=0, stallreq_if=0, inst_sram_addr=RESET_PC aligned and pc=RESET_PC.
REQ-026 SHALL abandon any pending redirect or WAIT state when rst_n asserts mid-operation, without waiting for a clock edge.

Verification
REQ-027 SHALL be tested with reset release, ready=1, stall=0 -> cycle 0 en=0; then pc=8000_0000, 8000_0004, 8000_0008 on successive cycles with pc_valid=1.
REQ-028 SHALL be tested with br_e=1, br_addr=8000_0103 at pc=8000_0008 -> next pc=8000_0100, then 8000_0104.
REQ-029 SHALL be tested with br_e pulse (addr 8000_0200) during 3-cycle stall[0]=1 -> pc held for the stall; first unstalled update gives pc=8000_0200; pend_v then 0.
REQ-030 SHALL be tested with inst_sram_ready=0 for 2 cycles -> stallreq_if=1 and pc_valid=0 for both cycles, pc unchanged; resumes +4 after ready returns.
REQ-031 SHALL be tested with RESET_PC=64'hFFFF_FFFF_FFFF_FFFC -> second fetch pc=0.
REQ-032 SHALL be tested with rst_n low mid-WAIT with a pending redirect -> outputs reach their reset values immediately, and fetch restarts at RESET_PC with no redirect.
